// File: rtl/axim_stream_responder.sv
// axim_stream_responder
//
// Responder end of the memory-subsystem AXIM control/stream interface. It stands in for
// an AXI master plus DDR. Read commands fetch words from an external dual-port synchronous
// word RAM and stream them out. Write commands sink the incoming stream into that RAM.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   ctrl_r*                   read command (byte offset, byte size, start strobe, done pulse)
//   rd_t*                     read stream out (data/valid/ready/last)
//   ctrl_w*                   write command (byte offset, byte size, start strobe, done pulse)
//   wr_t*                     write stream in (data/valid/ready)
//   mem_r*                    RAM read port; data returns one cycle after mem_ren_o
//   mem_w*                    RAM write port
module axim_stream_responder #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned MEM_AW             = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  input  logic                          ctrl_rstart_i,
  output logic                          ctrl_rdone_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i,
  input  logic                          ctrl_wstart_i,
  output logic                          ctrl_wdone_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i,
  input  logic                          wr_tvalid_i,
  output logic                          wr_tready_o,
  output logic [MEM_AW-1:0]             mem_raddr_o,
  output logic                          mem_ren_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [MEM_AW-1:0]             mem_waddr_o,
  output logic                          mem_we_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] mem_wdata_o
);

  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned XW = C_XFER_SIZE_WIDTH;

  typedef enum logic [1:0] {RIdle, RRun, RDone} r_state_e;
  typedef enum logic [1:0] {WIdle, WRun, WDone} w_state_e;

  // Byte-granular fields that play no part in word addressing.
  logic unused_bits;
  assign unused_bits = ^{ctrl_raddr_offset_i[1:0], ctrl_raddr_offset_i[C_M_AXI_ADDR_WIDTH-1:MEM_AW+2],
                         ctrl_waddr_offset_i[1:0], ctrl_waddr_offset_i[C_M_AXI_ADDR_WIDTH-1:MEM_AW+2],
                         ctrl_rxfer_size_i[1:0], ctrl_wxfer_size_i[1:0]};

  logic [XW-1:0] r_beats, w_beats;
  assign r_beats = {2'b00, ctrl_rxfer_size_i[XW-1:2]};
  assign w_beats = {2'b00, ctrl_wxfer_size_i[XW-1:2]};

  // ---------------------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------------------
  r_state_e          r_state_q, r_state_d;
  logic [MEM_AW-1:0] r_addr_q, r_addr_d;
  logic [XW-1:0]     r_total_q, r_total_d;
  logic [XW-1:0]     r_issued_q, r_issued_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [DW-1:0]     f_data_q [2];
  logic [DW-1:0]     f_data_d [2];
  logic [1:0]        f_last_q, f_last_d;
  logic              f_wptr_q, f_wptr_d;
  logic              f_rptr_q, f_rptr_d;
  logic [1:0]        f_cnt_q, f_cnt_d;

  logic       rd_pop;
  logic       rd_issue;
  logic [2:0] occ_after;

  assign rd_tvalid_o = (f_cnt_q != 2'd0);
  assign rd_tdata_o  = rd_tvalid_o ? f_data_q[f_rptr_q] : '0;
  assign rd_tlast_o  = rd_tvalid_o & f_last_q[f_rptr_q];
  assign rd_pop      = rd_tvalid_o & rd_tready_i;

  // Occupancy counts the beat leaving this cycle as already gone, so a steady ready stream
  // keeps one read in flight behind the head and sustains one beat per cycle.
  assign occ_after = {1'b0, f_cnt_q} + {2'b00, infl_q} - {2'b00, rd_pop};
  assign rd_issue  = (r_state_q == RRun) && (r_issued_q != r_total_q) && (occ_after < 3'd2);

  assign mem_ren_o    = rd_issue;
  assign mem_raddr_o  = r_addr_q;
  assign ctrl_rdone_o = (r_state_q == RDone);

  always_comb begin
    r_state_d   = r_state_q;
    r_addr_d    = r_addr_q;
    r_total_d   = r_total_q;
    r_issued_d  = r_issued_q;
    infl_d      = rd_issue;
    infl_last_d = rd_issue && (r_issued_q == r_total_q - XW'(1));
    case (r_state_q)
      RIdle: begin
        if (ctrl_rstart_i) begin
          r_addr_d   = ctrl_raddr_offset_i[MEM_AW+1:2];
          r_total_d  = r_beats;
          r_issued_d = '0;
          r_state_d  = (r_beats == '0) ? RDone : RRun;
        end
      end
      RRun: begin
        if (rd_issue) begin
          r_addr_d   = r_addr_q + MEM_AW'(1);
          r_issued_d = r_issued_q + XW'(1);
        end
        if (rd_pop && f_last_q[f_rptr_q]) begin
          r_state_d = RDone;
        end
      end
      RDone:   r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Two-entry output FIFO fed by the RAM one cycle after each issued read.
  always_comb begin
    f_data_d = f_data_q;
    f_last_d = f_last_q;
    f_wptr_d = f_wptr_q;
    f_rptr_d = f_rptr_q;
    if (infl_q) begin
      f_data_d[f_wptr_q] = mem_rdata_i;
      f_last_d[f_wptr_q] = infl_last_q;
      f_wptr_d           = ~f_wptr_q;
    end
    if (rd_pop) begin
      f_rptr_d = ~f_rptr_q;
    end
    f_cnt_d = f_cnt_q + {1'b0, infl_q} - {1'b0, rd_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= RIdle;
      r_addr_q    <= '0;
      r_total_q   <= '0;
      r_issued_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      f_data_q    <= '{default: '0};
      f_last_q    <= '0;
      f_wptr_q    <= 1'b0;
      f_rptr_q    <= 1'b0;
      f_cnt_q     <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_addr_q    <= r_addr_d;
      r_total_q   <= r_total_d;
      r_issued_q  <= r_issued_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      f_data_q    <= f_data_d;
      f_last_q    <= f_last_d;
      f_wptr_q    <= f_wptr_d;
      f_rptr_q    <= f_rptr_d;
      f_cnt_q     <= f_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------
  w_state_e          w_state_q, w_state_d;
  logic [MEM_AW-1:0] w_addr_q, w_addr_d;
  logic [XW-1:0]     w_total_q, w_total_d;
  logic [XW-1:0]     w_cnt_q, w_cnt_d;
  logic              w_beat;

  assign wr_tready_o  = (w_state_q == WRun);
  assign w_beat       = wr_tready_o & wr_tvalid_i;
  assign mem_we_o     = w_beat;
  assign mem_waddr_o  = w_addr_q;
  assign mem_wdata_o  = w_beat ? wr_tdata_i : '0;
  assign ctrl_wdone_o = (w_state_q == WDone);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_total_d = w_total_q;
    w_cnt_d   = w_cnt_q;
    case (w_state_q)
      WIdle: begin
        if (ctrl_wstart_i) begin
          w_addr_d  = ctrl_waddr_offset_i[MEM_AW+1:2];
          w_total_d = w_beats;
          w_cnt_d   = '0;
          w_state_d = (w_beats == '0) ? WDone : WRun;
        end
      end
      WRun: begin
        if (w_beat) begin
          w_addr_d = w_addr_q + MEM_AW'(1);
          w_cnt_d  = w_cnt_q + XW'(1);
          if (w_cnt_q + XW'(1) == w_total_q) begin
            w_state_d = WDone;
          end
        end
      end
      WDone:   w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= WIdle;
      w_addr_q  <= '0;
      w_total_q <= '0;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_total_q <= w_total_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_axim_stream_responder.sv
// Self-checking bench for axim_stream_responder. A RAM model answers the DUT's memory
// ports; expected beats, addresses and done pulses are queued when commands are issued and
// consumed as the DUT produces them.
module tb_axim_stream_responder;

  localparam int unsigned AW    = 12;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ctrl_raddr_offset_i, ctrl_rxfer_size_i;
  logic          ctrl_rstart_i, ctrl_rdone_o;
  logic [31:0]   rd_tdata_o;
  logic          rd_tvalid_o, rd_tready_i, rd_tlast_o;
  logic [31:0]   ctrl_waddr_offset_i, ctrl_wxfer_size_i;
  logic          ctrl_wstart_i, ctrl_wdone_o;
  logic [31:0]   wr_tdata_i;
  logic          wr_tvalid_i, wr_tready_o;
  logic [AW-1:0] mem_raddr_o, mem_waddr_o;
  logic          mem_ren_o, mem_we_o;
  logic [31:0]   mem_rdata_i, mem_wdata_o;

  always #5 clk = ~clk;

  axim_stream_responder #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_XFER_SIZE_WIDTH (32),
    .MEM_AW            (AW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_raddr_offset_i(ctrl_raddr_offset_i),
    .ctrl_rxfer_size_i  (ctrl_rxfer_size_i),
    .ctrl_rstart_i      (ctrl_rstart_i),
    .ctrl_rdone_o       (ctrl_rdone_o),
    .rd_tdata_o         (rd_tdata_o),
    .rd_tvalid_o        (rd_tvalid_o),
    .rd_tready_i        (rd_tready_i),
    .rd_tlast_o         (rd_tlast_o),
    .ctrl_waddr_offset_i(ctrl_waddr_offset_i),
    .ctrl_wxfer_size_i  (ctrl_wxfer_size_i),
    .ctrl_wstart_i      (ctrl_wstart_i),
    .ctrl_wdone_o       (ctrl_wdone_o),
    .wr_tdata_i         (wr_tdata_i),
    .wr_tvalid_i        (wr_tvalid_i),
    .wr_tready_o        (wr_tready_o),
    .mem_raddr_o        (mem_raddr_o),
    .mem_ren_o          (mem_ren_o),
    .mem_rdata_i        (mem_rdata_i),
    .mem_waddr_o        (mem_waddr_o),
    .mem_we_o           (mem_we_o),
    .mem_wdata_o        (mem_wdata_o)
  );

  // Dual-port synchronous RAM, preloaded with word k = k.
  logic [31:0] ram [Depth];
  initial begin
    for (int k = 0; k < Depth; k++) ram[k] = 32'(k);
    forever begin
      @(posedge clk);
      if (mem_ren_o) mem_rdata_i <= ram[mem_raddr_o];
      if (mem_we_o) ram[mem_waddr_o] <= mem_wdata_o;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] rq  [$];  // expected read beats
  logic [31:0] raq [$];  // expected RAM read addresses
  logic [31:0] waq [$];  // expected RAM write addresses
  logic [31:0] wdq [$];  // expected RAM write data
  logic [31:0] exp_mem [Depth];

  bit r_busy, w_busy, w_run, exp_rdone, exp_wdone;
  bit rd_rand, wr_rand, hold;
  bit ren_pend, vld_pend;
  int rstart_cyc, first_valid_cyc, last_hs_cyc;
  int w_total, wbeat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":rd_tvalid"}, 32'(rd_tvalid_o), 0);
    chk({tag, ":rd_tlast"}, 32'(rd_tlast_o), 0);
    chk({tag, ":rd_tdata"}, rd_tdata_o, 0);
    chk({tag, ":wr_tready"}, 32'(wr_tready_o), 0);
    chk({tag, ":rdone"}, 32'(ctrl_rdone_o), 0);
    chk({tag, ":wdone"}, 32'(ctrl_wdone_o), 0);
    chk({tag, ":mem_ren"}, 32'(mem_ren_o), 0);
    chk({tag, ":mem_we"}, 32'(mem_we_o), 0);
    chk({tag, ":mem_raddr"}, 32'(mem_raddr_o), 0);
    chk({tag, ":mem_waddr"}, 32'(mem_waddr_o), 0);
    chk({tag, ":mem_wdata"}, mem_wdata_o, 0);
  endtask

  task automatic reset_model();
    rq.delete(); raq.delete(); waq.delete(); wdq.delete();
    r_busy = 0; w_busy = 0; w_run = 0; exp_rdone = 0; exp_wdone = 0;
    ren_pend = 0; vld_pend = 0; w_total = 0; wbeat = 0;
  endtask

  // Called once per cycle after inputs settle; checks outputs and advances the model.
  task automatic monitor();
    bit            nxt_rdone = 0;
    bit            nxt_wdone = 0;
    bit            nxt_wrun;
    bit            exp_we;
    logic [31:0]   n, wa, wd;
    logic [AW-1:0] a;
    nxt_wrun = w_run;

    chk("rdone", 32'(ctrl_rdone_o), 32'(exp_rdone));
    chk("wdone", 32'(ctrl_wdone_o), 32'(exp_wdone));
    chk("wr_tready", 32'(wr_tready_o), 32'(w_run));

    if (raq.size() == 0) chk("mem_ren_idle", 32'(mem_ren_o), 0);
    else if (mem_ren_o === 1'b1) begin
      if (ren_pend) begin
        chk("ren_latency", 32'(cyc - rstart_cyc), 1);
        ren_pend = 0;
      end
      chk("mem_raddr", 32'(mem_raddr_o), raq.pop_front());
    end

    if (rq.size() == 0) chk("rd_tvalid_idle", 32'(rd_tvalid_o), 0);
    else if (rd_tvalid_o === 1'b1) begin
      if (vld_pend) begin
        chk("tvalid_latency", 32'(cyc - rstart_cyc), 3);
        vld_pend        = 0;
        first_valid_cyc = cyc;
      end
      chk("rd_tdata", rd_tdata_o, rq[0]);
      chk("rd_tlast", 32'(rd_tlast_o), 32'(rq.size() == 1));
      if (rd_tready_i) begin
        void'(rq.pop_front());
        if (rq.size() == 0) begin
          nxt_rdone   = 1;
          last_hs_cyc = cyc;
        end
      end
    end

    exp_we = wr_tvalid_i && w_run;
    chk("mem_we", 32'(mem_we_o), 32'(exp_we));
    if (exp_we) begin
      wa = waq.pop_front();
      wd = wdq.pop_front();
      chk("mem_waddr", 32'(mem_waddr_o), wa);
      chk("mem_wdata", mem_wdata_o, wd);
      exp_mem[wa[AW-1:0]] = wd;
      wbeat++;
      if (waq.size() == 0) begin
        nxt_wrun  = 0;
        nxt_wdone = 1;
      end
    end

    if (ctrl_rstart_i && !r_busy) begin
      r_busy = 1;
      n = {2'b00, ctrl_rxfer_size_i[31:2]};
      if (n == 0) nxt_rdone = 1;
      else begin
        rstart_cyc = cyc;
        ren_pend   = 1;
        vld_pend   = 1;
        for (int i = 0; i < int'(n); i++) begin
          a = ctrl_raddr_offset_i[AW+1:2] + AW'(i);
          raq.push_back(32'(a));
          rq.push_back(exp_mem[a]);
        end
      end
    end

    if (ctrl_wstart_i && !w_busy) begin
      w_busy  = 1;
      n       = {2'b00, ctrl_wxfer_size_i[31:2]};
      w_total = int'(n);
      wbeat   = 0;
      if (n == 0) nxt_wdone = 1;
      else begin
        nxt_wrun = 1;
        for (int i = 0; i < int'(n); i++) begin
          a = ctrl_waddr_offset_i[AW+1:2] + AW'(i);
          waq.push_back(32'(a));
          wdq.push_back(32'(i));
        end
      end
    end

    if (exp_rdone) r_busy = 0;
    if (exp_wdone) w_busy = 0;
    exp_rdone = nxt_rdone;
    exp_wdone = nxt_wdone;
    w_run     = nxt_wrun;
  endtask

  task automatic cycle();
    rd_tready_i = hold ? 1'b0 : (rd_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    wr_tvalid_i = !hold && (wbeat < w_total) && (wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    wr_tdata_i  = 32'(wbeat);
    #1;
    monitor();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((r_busy || w_busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_within_budget", {30'b0, r_busy, w_busy}, 0);
  endtask

  initial begin
    rst = 1'b1;
    ctrl_raddr_offset_i = '0; ctrl_rxfer_size_i = '0; ctrl_rstart_i = 1'b0;
    ctrl_waddr_offset_i = '0; ctrl_wxfer_size_i = '0; ctrl_wstart_i = 1'b0;
    rd_tready_i = 1'b0; wr_tvalid_i = 1'b0; wr_tdata_i = '0;
    hold = 0; rd_rand = 0; wr_rand = 0;
    reset_model();
    for (int k = 0; k < Depth; k++) exp_mem[k] = 32'(k);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Full-size read with ready held high.
    ctrl_raddr_offset_i = 32'h0; ctrl_rxfer_size_i = 32'd4096; ctrl_rstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0;
    wait_idle(3000);
    chk("read_throughput", 32'(last_hs_cyc - first_valid_cyc), 1023);
    repeat (3) cycle();

    // Same read with ready randomised.
    rd_rand = 1;
    ctrl_rstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0;
    wait_idle(8000);
    rd_rand = 0;
    repeat (3) cycle();

    // Full-size write with valid randomised, data = beat index.
    wr_rand = 1;
    ctrl_waddr_offset_i = 32'h100; ctrl_wxfer_size_i = 32'd4096; ctrl_wstart_i = 1'b1;
    cycle();
    ctrl_wstart_i = 1'b0;
    wait_idle(8000);
    wr_rand = 0;
    repeat (3) cycle();
    for (int k = 0; k < 1024; k++) chk("ram_content", ram[64+k], 32'(k));

    // Zero-beat read and write (size 3 also rounds down to zero beats).
    ctrl_rxfer_size_i = 32'd0; ctrl_wxfer_size_i = 32'd3;
    ctrl_rstart_i = 1'b1; ctrl_wstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0; ctrl_wstart_i = 1'b0;
    chk("size0_rdone", 32'(ctrl_rdone_o), 1);
    chk("size0_wdone", 32'(ctrl_wdone_o), 1);
    repeat (3) cycle();

    // Read across the top of the RAM; a second start mid-transfer is ignored.
    ctrl_raddr_offset_i = 32'h3FF8; ctrl_rxfer_size_i = 32'd16; ctrl_rstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0;
    repeat (2) cycle();
    ctrl_raddr_offset_i = 32'h0; ctrl_rxfer_size_i = 32'd8; ctrl_rstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0;
    wait_idle(100);
    repeat (3) cycle();

    // Concurrent read and write on disjoint regions, aborted by reset.
    rd_rand = 1; wr_rand = 1;
    ctrl_raddr_offset_i = 32'h2000; ctrl_rxfer_size_i = 32'd1600; ctrl_rstart_i = 1'b1;
    ctrl_waddr_offset_i = 32'h3000; ctrl_wxfer_size_i = 32'd1600; ctrl_wstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0; ctrl_wstart_i = 1'b0;
    repeat (40) cycle();
    hold = 1;
    rst  = 1'b1;
    cycle();
    reset_model();
    rst  = 1'b0;
    hold = 0; rd_rand = 0; wr_rand = 0;
    check_zero("abort");
    repeat (5) cycle();

    // Fresh read over the region written earlier.
    ctrl_raddr_offset_i = 32'h100; ctrl_rxfer_size_i = 32'd64; ctrl_rstart_i = 1'b1;
    cycle();
    ctrl_rstart_i = 1'b0;
    wait_idle(200);
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
